occ_rom_arbiter: RTL and testbench

Shares the single-port rom_Occ between two Occ-lookup requesters: port 0 for the k-side lookup and port 1 for the l-side lookup. It serialises their reads with round-robin arbitration and drives the ROM enable and address. It waits out the ROM read latency, then returns the 32-bit Occ word (four 8-bit counts: A=[7:0], C=[15:8], G=[23:16], T=[31:24]) with a one-cycle acknowledge. If both ports request the same address in the same cycle, one ROM access serves both.

---
 rtl/occ_rom_arbiter.sv | 114 +++++++++++
 tb/tb_occ_rom_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/occ_rom_arbiter.sv
// rtl/occ_rom_arbiter.sv - round-robin arbiter sharing single-port rom_Occ between k-side and l-side lookups
module occ_rom_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int ROM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              ce_rom_Occ,
  output logic [ADDR_W-1:0] addr_rom_Occ,
  input  logic [DATA_W-1:0] rom_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  // Counter preload so that WAIT spans exactly ROM_LATENCY edges.
  localparam logic [2:0] WAIT_LOAD = 3'(ROM_LATENCY - 1);

  state_t              state;
  logic                rr_ptr;
  logic [1:0]          grant;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          wait_cnt;

  logic [1:0]          pick;
  logic [ADDR_W-1:0]   pick_addr;

  // Arbitration: equal addresses merge into one access, otherwise rr_ptr breaks ties.
  always_comb begin
    pick      = 2'b00;
    pick_addr = addr0;
    if (req0 && req1) begin
      if (addr0 == addr1) begin
        pick = 2'b11;
      end else if (rr_ptr) begin
        pick      = 2'b10;
        pick_addr = addr1;
      end else begin
        pick = 2'b01;
      end
    end else if (req0) begin
      pick = 2'b01;
    end else if (req1) begin
      pick      = 2'b10;
      pick_addr = addr1;
    end
  end

  // Access sequencer: one outstanding ROM read, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= 1'b0;
      grant        <= 2'b00;
      addr_q       <= '0;
      wait_cnt     <= '0;
      ce_rom_Occ   <= 1'b0;
      addr_rom_Occ <= '0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata        <= '0;
      busy         <= 1'b0;
    end else begin
      busy       <= (state != IDLE);
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      ce_rom_Occ <= 1'b0;
      case (state)
        IDLE: begin
          if (pick != 2'b00) begin
            grant  <= pick;
            addr_q <= pick_addr;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          ce_rom_Occ   <= 1'b1;
          addr_rom_Occ <= addr_q;
          wait_cnt     <= WAIT_LOAD;
          state        <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            rdata <= rom_data;
            state <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        ACK: begin
          ack0 <= grant[0];
          ack1 <= grant[1];
          // A lone winner hands priority to the other port; a merged access leaves it alone.
          if (grant == 2'b01) begin
            rr_ptr <= 1'b1;
          end else if (grant == 2'b10) begin
            rr_ptr <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// tb/tb_occ_rom_arbiter.sv - self-checking bench for occ_rom_arbiter
module tb_occ_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [7:0]  addr0, addr1;
  logic        ack0, ack1, busy, ce;
  logic [31:0] rdata, rom_data;
  logic [7:0]  rom_addr;

  logic        req0_3, req1_3;
  logic [7:0]  addr0_3, addr1_3;
  logic        ack0_3, ack1_3, busy_3, ce_3;
  logic [31:0] rdata_3, rom_data_3;
  logic [7:0]  rom_addr_3;
  logic [31:0] p3a, p3b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    if (a == 8'h12) return 32'hAABBCCDD;
    return {~a, a ^ 8'h3C, a + 8'd77, a};
  endfunction

  occ_rom_arbiter #(.ADDR_W(8), .DATA_W(32), .ROM_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .ce_rom_Occ(ce),
    .addr_rom_Occ(rom_addr), .rom_data(rom_data));

  occ_rom_arbiter #(.ADDR_W(8), .DATA_W(32), .ROM_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req0(req0_3), .addr0(addr0_3), .req1(req1_3), .addr1(addr1_3),
    .ack0(ack0_3), .ack1(ack1_3), .rdata(rdata_3), .busy(busy_3), .ce_rom_Occ(ce_3),
    .addr_rom_Occ(rom_addr_3), .rom_data(rom_data_3));

  // ROM with latency 1: data valid only while ce is high; garbage otherwise.
  assign rom_data = ce ? rom_word(rom_addr) : 32'hDEADBEEF;

  // ROM with latency 3: two pipeline stages after the ce cycle.
  always @(posedge clk) begin
    p3a <= ce_3 ? rom_word(rom_addr_3) : 32'hDEADBEEF;
    p3b <= p3a;
  end
  assign rom_data_3 = p3b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    req0_3 = 0; req1_3 = 0; addr0_3 = 0; addr1_3 = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic read_port0(input logic [7:0] a);
    bit seen = 0;
    req0 = 1'b1; addr0 = a;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (ack0) begin
        seen = 1;
        req0 = 1'b0;
        n_checks++; if (rdata !== rom_word(a)) begin n_errors++; $display("FAIL read0_rdata: got %h want %h", rdata, rom_word(a)); end
      end
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL read0_timeout: got no ack0 want ack0"); req0 = 1'b0; end
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (ce !== 1'b0) begin n_errors++; $display("FAIL reset_ce: got %b want 0", ce); end
    n_checks++; if (rom_addr !== 8'h00) begin n_errors++; $display("FAIL reset_addr: got %h want 00", rom_addr); end
    n_checks++; if ({ack0, ack1} !== 2'b00) begin n_errors++; $display("FAIL reset_ack: got %b want 00", {ack0, ack1}); end
    n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (dut.rr_ptr !== 1'b0) begin n_errors++; $display("FAIL reset_rr: got %b want 0", dut.rr_ptr); end
  endtask

  task automatic test_single();
    apply_reset();
    req0 = 1'b1; addr0 = 8'h12;
    for (int k = 0; k <= 5; k++) begin
      tick();
      n_checks++; if (ce !== (k == 1)) begin n_errors++; $display("FAIL single_ce T+%0d: got %b want %b", k, ce, k == 1); end
      n_checks++; if (ack0 !== (k == 3)) begin n_errors++; $display("FAIL single_ack0 T+%0d: got %b want %b", k, ack0, k == 3); end
      n_checks++; if (ack1 !== 1'b0) begin n_errors++; $display("FAIL single_ack1 T+%0d: got %b want 0", k, ack1); end
      n_checks++; if (busy !== (k >= 1 && k <= 3)) begin n_errors++; $display("FAIL single_busy T+%0d: got %b want %b", k, busy, k >= 1 && k <= 3); end
      if (k == 1) begin
        n_checks++; if (rom_addr !== 8'h12) begin n_errors++; $display("FAIL single_addr: got %h want 12", rom_addr); end
      end
      if (k == 3) begin
        n_checks++; if (rdata !== 32'hAABBCCDD) begin n_errors++; $display("FAIL single_rdata: got %h want aabbccdd", rdata); end
        req0 = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    apply_reset();
    req0 = 1'b1; addr0 = 8'h05; req1 = 1'b1; addr1 = 8'h09;
    for (int k = 0; k <= 9; k++) begin
      tick();
      n_checks++; if (ce !== (k == 1 || k == 5)) begin n_errors++; $display("FAIL cont_ce T+%0d: got %b want %b", k, ce, k == 1 || k == 5); end
      n_checks++; if (ack0 !== (k == 3)) begin n_errors++; $display("FAIL cont_ack0 T+%0d: got %b want %b", k, ack0, k == 3); end
      n_checks++; if (ack1 !== (k == 7)) begin n_errors++; $display("FAIL cont_ack1 T+%0d: got %b want %b", k, ack1, k == 7); end
      if (k == 1) begin n_checks++; if (rom_addr !== 8'h05) begin n_errors++; $display("FAIL cont_addr0: got %h want 05", rom_addr); end end
      if (k == 5) begin n_checks++; if (rom_addr !== 8'h09) begin n_errors++; $display("FAIL cont_addr1: got %h want 09", rom_addr); end end
      if (k == 3) begin
        n_checks++; if (rdata !== rom_word(8'h05)) begin n_errors++; $display("FAIL cont_rdata0: got %h want %h", rdata, rom_word(8'h05)); end
        req0 = 1'b0;
      end
      if (k == 7) begin
        n_checks++; if (rdata !== rom_word(8'h09)) begin n_errors++; $display("FAIL cont_rdata1: got %h want %h", rdata, rom_word(8'h09)); end
        req1 = 1'b0;
      end
    end
    n_checks++; if (dut.rr_ptr !== 1'b0) begin n_errors++; $display("FAIL cont_rr: got %b want 0", dut.rr_ptr); end
  endtask

  task automatic test_fairness();
    int order[4];
    int n = 0;
    apply_reset();
    req0 = 1'b1; addr0 = 8'h10; req1 = 1'b1; addr1 = 8'h21;
    for (int i = 0; i < 40 && n < 4; i++) begin
      tick();
      n_checks++; if (ack0 && ack1) begin n_errors++; $display("FAIL fair_both_ack: got 11 want single ack"); end
      if (ack0 || ack1) begin
        order[n] = ack1 ? 1 : 0;
        n_checks++; if (rdata !== rom_word(ack1 ? addr1 : addr0)) begin n_errors++; $display("FAIL fair_rdata: got %h want %h", rdata, rom_word(ack1 ? addr1 : addr0)); end
        if (ack0) addr0 = addr0 + 8'd2;
        if (ack1) addr1 = addr1 + 8'd2;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    n_checks++; if (n != 4) begin n_errors++; $display("FAIL fair_timeout: got %0d grants want 4", n); end
    for (int j = 0; j < n; j++) begin
      n_checks++; if (order[j] != (j % 2)) begin n_errors++; $display("FAIL fair_order[%0d]: got port %0d want port %0d", j, order[j], j % 2); end
    end
    tick(); tick();
  endtask

  task automatic test_merge();
    int ce_cnt = 0, both_cnt = 0, lone_cnt = 0;
    apply_reset();
    read_port0(8'h01);
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h40; addr1 = 8'h40;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (ce) ce_cnt++;
      if (ack0 && ack1) begin
        both_cnt++;
        n_checks++; if (rdata !== rom_word(8'h40)) begin n_errors++; $display("FAIL merge_rdata: got %h want %h", rdata, rom_word(8'h40)); end
        req0 = 1'b0; req1 = 1'b0;
      end else if (ack0 || ack1) begin
        lone_cnt++;
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    n_checks++; if (ce_cnt != 1) begin n_errors++; $display("FAIL merge_ce_count: got %0d want 1", ce_cnt); end
    n_checks++; if (both_cnt != 1) begin n_errors++; $display("FAIL merge_joint_ack: got %0d want 1", both_cnt); end
    n_checks++; if (lone_cnt != 0) begin n_errors++; $display("FAIL merge_lone_ack: got %0d want 0", lone_cnt); end
    n_checks++; if (dut.rr_ptr !== 1'b1) begin n_errors++; $display("FAIL merge_rr: got %b want 1", dut.rr_ptr); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    read_port0(8'h01);
    req0 = 1'b1; addr0 = 8'h33;
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_checks++; if (ce !== 1'b0) begin n_errors++; $display("FAIL rmid_ce: got %b want 0", ce); end
    n_checks++; if ({ack0, ack1} !== 2'b00) begin n_errors++; $display("FAIL rmid_ack: got %b want 00", {ack0, ack1}); end
    n_checks++; if (rdata !== 32'h0) begin n_errors++; $display("FAIL rmid_rdata: got %h want 0", rdata); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
    n_checks++; if (dut.rr_ptr !== 1'b0) begin n_errors++; $display("FAIL rmid_rr: got %b want 0", dut.rr_ptr); end
    rst = 1'b0; req0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if ({ack0, ack1, ce} !== 3'b000) begin n_errors++; $display("FAIL rmid_after: got ack/ce %b want 000", {ack0, ack1, ce}); end
    end
  endtask

  task automatic test_latency();
    apply_reset();
    req1_3 = 1'b1; addr1_3 = 8'hFF;
    tick();
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_checks++; if (ack1_3 !== (k == 5)) begin n_errors++; $display("FAIL lat_ack1 T+%0d: got %b want %b", k, ack1_3, k == 5); end
      n_checks++; if (ack0_3 !== 1'b0) begin n_errors++; $display("FAIL lat_ack0 T+%0d: got %b want 0", k, ack0_3); end
      n_checks++; if (busy_3 !== (k <= 5)) begin n_errors++; $display("FAIL lat_busy T+%0d: got %b want %b", k, busy_3, k <= 5); end
      n_checks++; if (ce_3 !== (k == 1)) begin n_errors++; $display("FAIL lat_ce T+%0d: got %b want %b", k, ce_3, k == 1); end
      if (k == 5) begin
        n_checks++; if (rdata_3 !== rom_word(8'hFF)) begin n_errors++; $display("FAIL lat_rdata: got %h want %h", rdata_3, rom_word(8'hFF)); end
        req1_3 = 1'b0;
      end
    end
  endtask

  // Transaction-level model: a grant at edge g gives ce at g+1, data at g+1+L,
  // ack at g+2+L, and the arbiter is free to grant again from g+3+L.
  task automatic test_random(input int n_cyc);
    localparam int L = 1;
    int g_cyc = -100, free_cyc = 0;
    logic [1:0] gvec = 2'b00, e_ack, pend = 2'b00;
    logic [7:0] gaddr = 8'h00, e_addr = 8'h00;
    logic [31:0] e_rdata = 32'h0;
    logic e_ce, e_busy, mrr = 1'b0;
    apply_reset();
    for (int c = 0; c < n_cyc; c++) begin
      @(posedge clk);
      e_ce   = (c == g_cyc + 1);
      e_ack  = (c == g_cyc + 2 + L) ? gvec : 2'b00;
      e_busy = (c >= g_cyc + 1) && (c <= g_cyc + 2 + L);
      if (e_ce) e_addr = gaddr;
      if (c == g_cyc + 1 + L) e_rdata = rom_word(gaddr);
      if (e_ack != 2'b00) pend = 2'b00;
      if (c >= free_cyc && (req0 || req1)) begin
        if (req0 && req1 && addr0 == addr1) begin gvec = 2'b11; gaddr = addr0; end
        else if (req0 && req1) begin gvec = mrr ? 2'b10 : 2'b01; gaddr = mrr ? addr1 : addr0; end
        else if (req0) begin gvec = 2'b01; gaddr = addr0; end
        else begin gvec = 2'b10; gaddr = addr1; end
        if (gvec == 2'b01) mrr = 1'b1;
        if (gvec == 2'b10) mrr = 1'b0;
        pend = gvec;
        g_cyc = c;
        free_cyc = c + 3 + L;
      end
      #1;
      n_checks++; if ({ack1, ack0} !== e_ack) begin n_errors++; $display("FAIL rand_ack c=%0d: got %b want %b", c, {ack1, ack0}, e_ack); end
      n_checks++; if (ce !== e_ce) begin n_errors++; $display("FAIL rand_ce c=%0d: got %b want %b", c, ce, e_ce); end
      n_checks++; if (rom_addr !== e_addr) begin n_errors++; $display("FAIL rand_addr c=%0d: got %h want %h", c, rom_addr, e_addr); end
      n_checks++; if (rdata !== e_rdata) begin n_errors++; $display("FAIL rand_rdata c=%0d: got %h want %h", c, rdata, e_rdata); end
      n_checks++; if (busy !== e_busy) begin n_errors++; $display("FAIL rand_busy c=%0d: got %b want %b", c, busy, e_busy); end
      if (e_ack[0]) begin
        if ($urandom_range(1, 0) == 1) addr0 = 8'($urandom_range(3, 0)); else req0 = 1'b0;
      end else if (!req0) begin
        if ($urandom_range(2, 0) == 0) begin req0 = 1'b1; addr0 = 8'($urandom_range(3, 0)); end
      end else if (!pend[0] && $urandom_range(3, 0) == 0) addr0 = 8'($urandom_range(3, 0));
      if (e_ack[1]) begin
        if ($urandom_range(1, 0) == 1) addr1 = 8'($urandom_range(3, 0)); else req1 = 1'b0;
      end else if (!req1) begin
        if ($urandom_range(2, 0) == 0) begin req1 = 1'b1; addr1 = 8'($urandom_range(3, 0)); end
      end else if (!pend[1] && $urandom_range(3, 0) == 0) addr1 = 8'($urandom_range(3, 0));
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_merge();
    test_reset_mid();
    test_latency();
    test_random(400);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
